// File: rtl/bsg_scatter_serial.sv
// Serial scatter: takes a lane-occupancy mask, then drops each incoming data word
// into the next occupied lane (lowest index first) and presents the finished vector.
module bsg_scatter_serial #(
    parameter int els_p   = 32,
    parameter int width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       mask_v_i,
    input  logic [els_p-1:0]           mask_i,
    output logic                       mask_ready_o,

    input  logic                       data_v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       data_ready_o,

    output logic                       v_o,
    output logic [els_p*width_p-1:0]   data_o,
    output logic [els_p-1:0]           mask_o,
    input  logic                       yumi_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_reg;
    logic [els_p-1:0]   mask_reg;
    logic [els_p-1:0]   pend_reg;
    logic               mask_ready_reg;
    logic               data_ready_reg;
    logic               v_reg;

    logic [els_p-1:0]   lower_any;
    logic [els_p-1:0]   lowest;
    logic [els_p-1:0]   pend_next;
    logic               mask_acc;
    logic               data_acc;

    assign mask_acc  = (state_reg == IDLE) && mask_v_i;
    assign data_acc  = (state_reg == FILL) && data_v_i;
    assign pend_next = pend_reg & ~lowest;

    // Priority chain: lowest[i] is set only for the first pending lane.
    genvar gi;
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_prio
            if (gi == 0) begin : g_first
                assign lower_any[gi] = 1'b0;
            end else begin : g_rest
                assign lower_any[gi] = lower_any[gi-1] | pend_reg[gi-1];
            end
            assign lowest[gi] = pend_reg[gi] & ~lower_any[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg      <= IDLE;
            mask_reg       <= '0;
            pend_reg       <= '0;
            mask_ready_reg <= 1'b1;
            data_ready_reg <= 1'b0;
            v_reg          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mask_v_i) begin
                        mask_reg       <= mask_i;
                        pend_reg       <= mask_i;
                        mask_ready_reg <= 1'b0;
                        if (mask_i != '0) begin
                            state_reg      <= FILL;
                            data_ready_reg <= 1'b1;
                        end else begin
                            state_reg <= DONE;
                            v_reg     <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (data_v_i) begin
                        pend_reg <= pend_next;
                        if (pend_next == '0) begin
                            state_reg      <= DONE;
                            data_ready_reg <= 1'b0;
                            v_reg          <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        state_reg      <= IDLE;
                        v_reg          <= 1'b0;
                        mask_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    pend_reg       <= '0;
                    mask_ready_reg <= 1'b1;
                    data_ready_reg <= 1'b0;
                    v_reg          <= 1'b0;
                end
            endcase
        end
    end

    // Each lane clears on a new mask so unoccupied lanes always read as zero.
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_lane
            logic [width_p-1:0] lane_reg;

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    lane_reg <= '0;
                end else if (mask_acc) begin
                    lane_reg <= '0;
                end else if (data_acc && lowest[gi]) begin
                    lane_reg <= data_i;
                end
            end

            assign data_o[gi*width_p +: width_p] = lane_reg;
        end
    endgenerate

    assign mask_ready_o = mask_ready_reg;
    assign data_ready_o = data_ready_reg;
    assign v_o          = v_reg;
    assign mask_o       = mask_reg;

endmodule

// File: tb/tb_bsg_scatter_serial.sv
// Bench for bsg_scatter_serial: directed scenarios plus random traffic against a
// queue-of-pending-lanes reference model.
module tb_bsg_scatter_serial;

    localparam int ELS = 32;
    localparam int W   = 8;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic                 mask_v_i;
    logic [ELS-1:0]       mask_i;
    logic                 mask_ready_o;
    logic                 data_v_i;
    logic [W-1:0]         data_i;
    logic                 data_ready_o;
    logic                 v_o;
    logic [ELS*W-1:0]     data_o;
    logic [ELS-1:0]       mask_o;
    logic                 yumi_i;

    bsg_scatter_serial #(.els_p(ELS), .width_p(W)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .mask_v_i     (mask_v_i),
        .mask_i       (mask_i),
        .mask_ready_o (mask_ready_o),
        .data_v_i     (data_v_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .mask_o       (mask_o),
        .yumi_i       (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a vector is "busy" once a mask is taken; q lists the
    // lanes still waiting for a word, in the order they must be filled.
    bit               busy;
    int               q[$];
    logic [ELS*W-1:0] exp_data;
    logic [ELS-1:0]   exp_mask;
    int               n_vec = 0;

    task automatic check(input string tag, input logic [ELS*W-1:0] obs, input logic [ELS*W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit exp_valid();
        return busy && (q.size() == 0);
    endfunction

    task automatic model_reset();
        busy     = 1'b0;
        q        = {};
        exp_data = '0;
        exp_mask = '0;
    endtask

    task automatic model_step(input bit mv, input logic [ELS-1:0] m, input bit dv,
                              input logic [W-1:0] d, input bit y);
        if (!busy) begin
            if (mv) begin
                busy     = 1'b1;
                exp_mask = m;
                exp_data = '0;
                q        = {};
                for (int i = 0; i < ELS; i++)
                    if (m[i]) q.push_back(i);
            end
        end else if (q.size() > 0) begin
            if (dv) begin
                int lane;
                lane = q.pop_front();
                exp_data[lane*W +: W] = d;
            end
        end else if (y) begin
            n_vec++;
            $display("vec %0d: mask=%08h data=%064h", n_vec, exp_mask, exp_data);
            busy = 1'b0;
        end
    endtask

    task automatic check_all();
        check("mask_ready", {255'd0, mask_ready_o}, {255'd0, !busy});
        check("data_ready", {255'd0, data_ready_o}, {255'd0, busy && q.size() > 0});
        check("v",          {255'd0, v_o},          {255'd0, exp_valid()});
        if (exp_valid()) begin
            check("mask_o", {224'd0, mask_o}, {224'd0, exp_mask});
            check("data_o", data_o, exp_data);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mask_ready"}, {255'd0, mask_ready_o}, 256'd1);
        check({tag, "_data_ready"}, {255'd0, data_ready_o}, 256'd0);
        check({tag, "_v"},          {255'd0, v_o},          256'd0);
        check({tag, "_data_o"},     data_o,                 256'd0);
        check({tag, "_mask_o"},     {224'd0, mask_o},       256'd0);
    endtask

    // Called at a negedge: check current outputs, drive inputs, clock once.
    task automatic cycle(input bit mv, input logic [ELS-1:0] m, input bit dv,
                         input logic [W-1:0] d, input bit y);
        check_all();
        mask_v_i = mv;
        mask_i   = m;
        data_v_i = dv;
        data_i   = d;
        yumi_i   = y;
        @(posedge clk_i);
        model_step(mv, m, dv, d, y);
        @(negedge clk_i);
    endtask

    initial begin
        logic [ELS-1:0] m;
        int r;
        reset_i  = 1'b1;
        mask_v_i = 1'b0;
        mask_i   = '0;
        data_v_i = 1'b0;
        data_i   = '0;
        yumi_i   = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        check_reset("por");
        reset_i = 1'b0;

        // Basic fill
        cycle(1, 32'h0000_0005, 0, 8'h00, 0);
        cycle(0, '0, 1, 8'hAA, 0);
        cycle(0, '0, 1, 8'hBB, 0);
        cycle(0, '0, 0, 8'h00, 1);

        // Full mask, with one extra word offered after the last lane
        cycle(1, 32'hFFFF_FFFF, 0, 8'h00, 0);
        for (int i = 0; i < ELS; i++) cycle(0, '0, 1, W'(i), 0);
        cycle(0, '0, 1, 8'hEE, 0);
        cycle(0, '0, 0, 8'h00, 1);

        // Zero mask, held in DONE for 5 cycles with stray data
        cycle(1, 32'h0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) cycle(0, '0, 1, 8'h77, 0);
        cycle(0, '0, 0, 8'h00, 1);

        // Backpressure and ignored inputs
        cycle(0, '0, 1, 8'h99, 0);
        cycle(1, 32'h8000_0001, 0, 8'h00, 0);
        for (int i = 0; i < 40 && !exp_valid(); i++)
            cycle(0, '0, 1'($urandom % 2), W'($urandom), 0);
        cycle(0, '0, 1, 8'h55, 0);
        cycle(0, '0, 1, 8'h66, 0);
        cycle(0, '0, 0, 8'h00, 1);

        // Back-to-back with mask_v held high
        cycle(1, 32'h3, 0, 8'h00, 0);
        cycle(1, 32'h10, 1, 8'h11, 0);
        cycle(1, 32'h10, 1, 8'h22, 0);
        cycle(1, 32'h10, 0, 8'h00, 1);
        cycle(1, 32'h10, 0, 8'h00, 0);
        cycle(0, '0, 1, 8'h33, 0);
        cycle(0, '0, 0, 8'h00, 1);

        // Asynchronous reset mid-FILL
        cycle(1, 32'hF, 0, 8'h00, 0);
        cycle(0, '0, 1, 8'h11, 0);
        cycle(0, '0, 1, 8'h22, 0);
        check_all();
        #2 reset_i = 1'b1;
        mask_v_i = 1'b1;
        mask_i   = 32'h7;
        #1 check_reset("rst_async");
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        check_reset("rst_hold");
        reset_i  = 1'b0;
        mask_v_i = 1'b0;
        cycle(1, 32'h1, 0, 8'h00, 0);
        cycle(0, '0, 1, 8'h5A, 0);
        cycle(0, '0, 0, 8'h00, 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom % 8);
            if (r == 0)      m = '0;
            else if (r == 1) m = '1;
            else if (r < 5)  m = $urandom & $urandom & $urandom;
            else             m = $urandom;
            cycle(($urandom % 3) == 0, m, 1'($urandom % 2), W'($urandom),
                  exp_valid() && (($urandom % 3) != 0));
        end
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
